dtc_rr_sched: RTL
=================

DTC_RR_SCHED -- requirements
Module: dtc_rr_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one decision-tree classifier; power of two, 2..8.
REQ-002 Parameter DW, default 8: classifier feature-vector width.
REQ-003 Parameter CW, default 2: classifier class-code width.
REQ-004 Parameter CNTW, default 16: width of each per-class result counter.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port req_valid  input  NREQ  per-requester request valid.
REQ-008 Port req_data  input  NREQ*DW  per-requester feature vector; requester i in bits [i*DW +: DW].
REQ-009 Port req_ready  output  NREQ  one-hot or zero grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 Port cls_inp  output  DW  feature vector driven to the external combinational classifier.
REQ-011 Port cls_outp  input  CW  class code returned combinationally by the classifier for cls_inp.
REQ-012 Port rsp_valid  output  1  response valid.
REQ-013 Port rsp_ready  input  1  response consumer ready; a response transfers when rsp_valid and rsp_ready are both high.
REQ-014 Port rsp_id  output  log2(NREQ)  index of the requester that issued the request.
REQ-015 Port rsp_class  output  CW  class code for that request.
REQ-016 Port cnt_clr  input  1  synchronous clear of all class counters.
REQ-017 Port cnt  output  (2**CW)*CNTW  per-class delivered-response counters; class k in bits [k*CNTW +: CNTW].

Function
REQ-018 Two-stage pipeline: stage S1 (operand register: valid, id, data) and stage S2 (response register: valid, id, class).
REQ-019 cls_inp SHALL equal the S1 data register at all times (registered output, no combinational path from req_data).
REQ-020 S2 loads {S1 id, cls_outp} when S1 is valid and S2 is empty or being drained (rsp_valid and rsp_ready) in the same cycle.
REQ-021 S1 may accept when S1 is empty or S1 advances to S2 in the same cycle; otherwise all req_ready bits are 0.
REQ-022 When S1 may accept, exactly one req_ready bit is high: that of the first valid requester in round-robin order starting at (last_grant+1) mod NREQ; all zero if no req_valid is high.
REQ-023 req_ready SHALL depend combinationally on req_valid; last_grant updates to the granted index only on a completed request transfer.
REQ-024 Latency: request transferring in cycle N produces rsp_valid in cycle N+2 when unstalled; sustained throughput one response per cycle.
REQ-025 rsp_valid, rsp_id, rsp_class SHALL be held stable while rsp_valid is high and rsp_ready is low.
REQ-026 Requests complete in grant order; no request is dropped or duplicated under any backpressure pattern.
REQ-027 On each response transfer, cnt for class rsp_class increments by 1, saturating at 2**CNTW-1.
REQ-028 cnt_clr set to 0 all counters in the next cycle; clear wins over a same-cycle increment.
REQ-029 Requesters that are not granted SHALL observe no state change; req_data is sampled only on transfer.

Reset
REQ-030 While rst is high at a clock edge: S1 and S2 valid cleared, rsp_valid=0, req_ready=0 during that cycle, last_grant=NREQ-1 (requester 0 first), all cnt=0.
REQ-031 Reset mid-operation discards in-flight S1/S2 contents without generating a response; data registers need not be reset; cls_inp value after reset is don't-care until first grant.
REQ-032 First cycle after rst deasserts, S1 may accept, so grant follows REQ-022.

Verification
REQ-033 Single request: req_valid=0001, req_data[7:0]=0x41, rsp_ready=1 -> req_ready=0001 in cycle N, cls_inp=0x41 in N+1, rsp_valid=1, rsp_id=0, rsp_class=cls_outp model value in N+2.
REQ-034 Fairness: req_valid=1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0,... one per cycle; rsp_id sequence matches.
REQ-035 Backpressure: rsp_ready=0 with continuous requests -> exactly two requests accepted, req_ready=0000 afterward, rsp outputs stable; rsp_ready=1 -> responses drain in order, grants resume same cycle.
REQ-036 Counters: deliver 3 responses of class 2 -> cnt class 2 = 3, others 0; cnt_clr together with a class-2 transfer -> all counters 0 next cycle; CNTW=4 with 20 class-1 responses -> count stays 15.
REQ-037 Reset mid-flight: rst high for one cycle with S1 and S2 valid -> rsp_valid=0 next cycle, no counter change, next grant goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/dtc_rr_sched.sv
// Round-robin front end sharing one combinational decision-tree classifier among NREQ requesters.
// Two-stage pipeline (operand register -> response register) with per-class saturating result counters.
module dtc_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 2,
    parameter int CNTW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*DW-1:0]          req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [DW-1:0]               cls_inp,
    input  logic [CW-1:0]               cls_outp,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic [CW-1:0]               rsp_class,
    input  logic                        cnt_clr,
    output logic [(2**CW)*CNTW-1:0]     cnt
);

    localparam int IDW  = $clog2(NREQ);
    localparam int NCLS = 2**CW;

    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic [DW-1:0]   s1_data;
    logic            s2_valid;
    logic [IDW-1:0]  s2_id;
    logic [CW-1:0]   s2_class;
    logic [IDW-1:0]  last_grant;
    logic [CNTW-1:0] cnt_q [NCLS];

    logic            s2_drain;
    logic            s2_load;
    logic            can_accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  rr_idx;
    logic            found;
    logic            req_xfer;

    assign s2_drain   = s2_valid & rsp_ready;
    assign s2_load    = s1_valid & (~s2_valid | s2_drain);
    assign can_accept = ~rst & (~s1_valid | s2_load);

    // Search starts just after the last granted requester; wrap-around comes free from the IDW-bit add.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        rr_idx    = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = last_grant + IDW'(k);
            if (!found && req_valid[rr_idx]) begin
                found            = 1'b1;
                grant[rr_idx]    = 1'b1;
                grant_idx        = rr_idx;
            end
        end
    end

    assign req_ready = can_accept ? grant : '0;
    assign req_xfer  = |(req_valid & req_ready);

    assign cls_inp   = s1_data;
    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_class = s2_class;

    // Payload registers are left out of reset; only the valid bits and the arbiter pointer are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_id    <= s1_id;
                s2_class <= cls_outp;
            end else if (s2_drain) begin
                s2_valid <= 1'b0;
            end

            if (req_xfer) begin
                s1_valid   <= 1'b1;
                s1_id      <= grant_idx;
                s1_data    <= req_data[grant_idx*DW +: DW];
                last_grant <= grant_idx;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Clear has priority over a same-cycle delivered response.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int k = 0; k < NCLS; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (s2_drain && (cnt_q[s2_class] != {CNTW{1'b1}})) begin
            cnt_q[s2_class] <= cnt_q[s2_class] + CNTW'(1);
        end
    end

    for (genvar g = 0; g < NCLS; g++) begin : g_cnt
        assign cnt[g*CNTW +: CNTW] = cnt_q[g];
    end

endmodule
